// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: queue entry layout,
// register-file geometry and a slice helper for the packed committed file.
package wb_pkg;

    localparam int NREGS = 16;
    localparam int WIDTH = 64;
    localparam int IDX_W = $clog2(NREGS);

    localparam logic [IDX_W-1:0] REG_RAX = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_RDX = IDX_W'(2);

    typedef struct packed {
        logic             en0;
        logic [IDX_W-1:0] dst0;
        logic [WIDTH-1:0] val0;
        logic             en1;
        logic [IDX_W-1:0] dst1;
        logic [WIDTH-1:0] val1;
        logic             halt;
    } wb_entry_t;

    function automatic logic [WIDTH-1:0] get_64(
        input logic [0:NREGS*WIDTH-1] file,
        input logic [IDX_W-1:0]       idx
    );
        return file[int'(idx)*WIDTH +: WIDTH];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries; presents every slot in age order
// (index 0 = head/oldest) with per-slot valid bits for forwarding.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  wb_entry_t                  push_data,
    input  logic                       pop,
    input  logic                       flush,
    output wb_entry_t                  entries [DEPTH],
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= push_data;
        end
    end

    always_comb begin
        valid = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            entries[k] = mem[head + PW'(k)];
            valid[k]   = (CW'(k) < count);
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: queues ALU results, commits them into the architectural
// register file, forwards pending writes to operand reads and latches halt.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int NREGS  = wb_pkg::NREGS,
    parameter int WIDTH  = wb_pkg::WIDTH,
    parameter int QDEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic                     wb_en0,
    input  logic [$clog2(NREGS)-1:0] wb_dst0,
    input  logic [WIDTH-1:0]         wb_val0,
    input  logic                     wb_en1,
    input  logic [$clog2(NREGS)-1:0] wb_dst1,
    input  logic [WIDTH-1:0]         wb_val1,
    input  logic                     wb_halt,
    input  logic                     commit_en,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic [WIDTH-1:0]         rd_data_b,
    output logic [NREGS-1:0]         busy_mask,
    output logic                     halted,
    output logic [0:NREGS*WIDTH-1]   reg_file
);

    localparam int CW = $clog2(QDEPTH+1);
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    wb_entry_t          push_data;
    wb_entry_t          q [QDEPTH];
    logic [QDEPTH-1:0]  q_valid;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;
    logic               halt_commit;
    logic [WIDTH-1:0]   regs [NREGS];

    assign wb_ready    = (count < QFULL) && !halted;
    assign push        = wb_valid && wb_ready;
    assign pop         = (count != '0) && commit_en;
    assign halt_commit = pop && q[0].halt;

    always_comb begin
        push_data      = '0;
        push_data.en0  = wb_en0;
        push_data.dst0 = wb_dst0;
        push_data.val0 = wb_val0;
        push_data.en1  = wb_en1;
        push_data.dst1 = wb_dst1;
        push_data.val1 = wb_val1;
        push_data.halt = wb_halt;
    end

    // Entries queued behind a committing halt (and any same-edge push) are dropped.
    wb_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (halt_commit),
        .entries   (q),
        .valid     (q_valid),
        .count     (count)
    );

    // Port 1 is written after port 0 so it wins on a shared destination.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            halted <= 1'b0;
        end else if (pop) begin
            if (q[0].en0) begin
                regs[q[0].dst0] <= q[0].val0;
            end
            if (q[0].en1) begin
                regs[q[0].dst1] <= q[0].val1;
            end
            if (q[0].halt) begin
                halted <= 1'b1;
            end
        end
    end

    // Slots scan oldest to youngest, so the youngest matching write is left standing.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        for (int unsigned k = 0; k < QDEPTH; k++) begin
            if (q_valid[k]) begin
                if (q[k].en0 && (q[k].dst0 == rd_addr_a)) rd_data_a = q[k].val0;
                if (q[k].en1 && (q[k].dst1 == rd_addr_a)) rd_data_a = q[k].val1;
                if (q[k].en0 && (q[k].dst0 == rd_addr_b)) rd_data_b = q[k].val0;
                if (q[k].en1 && (q[k].dst1 == rd_addr_b)) rd_data_b = q[k].val1;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned k = 0; k < QDEPTH; k++) begin
            if (q_valid[k]) begin
                if (q[k].en0) busy_mask = busy_mask | (NREGS'(1) << q[k].dst0);
                if (q[k].en1) busy_mask = busy_mask | (NREGS'(1) << q[k].dst1);
            end
        end
    end

    always_comb begin
        reg_file = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            reg_file[r*WIDTH +: WIDTH] = regs[r];
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised and directed bench for reg_writeback against a queue-based model.
module tb_reg_writeback;

    localparam int NR = 16;
    localparam int W  = 64;
    localparam int QD = 2;

    logic            clk;
    logic            reset_n;
    logic            wb_valid;
    logic            wb_ready;
    logic            wb_en0;
    logic [3:0]      wb_dst0;
    logic [W-1:0]    wb_val0;
    logic            wb_en1;
    logic [3:0]      wb_dst1;
    logic [W-1:0]    wb_val1;
    logic            wb_halt;
    logic            commit_en;
    logic [3:0]      rd_addr_a;
    logic [3:0]      rd_addr_b;
    logic [W-1:0]    rd_data_a;
    logic [W-1:0]    rd_data_b;
    logic [NR-1:0]   busy_mask;
    logic            halted;
    logic [0:NR*W-1] reg_file;

    reg_writeback #(
        .NREGS  (NR),
        .WIDTH  (W),
        .QDEPTH (QD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_en0    (wb_en0),
        .wb_dst0   (wb_dst0),
        .wb_val0   (wb_val0),
        .wb_en1    (wb_en1),
        .wb_dst1   (wb_dst1),
        .wb_val1   (wb_val1),
        .wb_halt   (wb_halt),
        .commit_en (commit_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy_mask (busy_mask),
        .halted    (halted),
        .reg_file  (reg_file)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending entries in arrival order, committed registers, halt flag.
    typedef struct {
        bit          en0;
        int          d0;
        logic [63:0] v0;
        bit          en1;
        int          d1;
        logic [63:0] v1;
        bit          halt;
    } ent_t;

    ent_t        pend[$];
    logic [63:0] m_regs [NR];
    bit          m_halted = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;

    initial begin
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
    end

    function automatic logic [63:0] m_read(input int a);
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].en1 && pend[i].d1 == a) return pend[i].v1;
            if (pend[i].en0 && pend[i].d0 == a) return pend[i].v0;
        end
        return m_regs[a];
    endfunction

    function automatic logic [63:0] m_busy();
        logic [63:0] m = '0;
        foreach (pend[i]) begin
            if (pend[i].en0) m[pend[i].d0] = 1'b1;
            if (pend[i].en1) m[pend[i].d1] = 1'b1;
        end
        return m;
    endfunction

    function automatic bit m_ready();
        return (pend.size() < QD) && !m_halted;
    endfunction

    function automatic logic [63:0] dut_reg(input int r);
        return reg_file[r*W +: W];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend.delete();
            for (int r = 0; r < NR; r++) m_regs[r] = '0;
            m_halted = 1'b0;
        end else begin
            bit   acc;
            bit   flushed;
            ent_t e;
            acc     = wb_valid && m_ready();
            flushed = 1'b0;
            if (commit_en && pend.size() > 0) begin
                e = pend.pop_front();
                if (e.en0) m_regs[e.d0] = e.v0;
                if (e.en1) m_regs[e.d1] = e.v1;
                if (e.halt) begin
                    m_halted = 1'b1;
                    pend.delete();
                    flushed = 1'b1;
                end
            end
            if (acc && !flushed) begin
                e.en0  = wb_en0;
                e.d0   = int'(wb_dst0);
                e.v0   = wb_val0;
                e.en1  = wb_en1;
                e.d1   = int'(wb_dst1);
                e.v1   = wb_val1;
                e.halt = wb_halt;
                pend.push_back(e);
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, " wb_ready"},  64'(wb_ready),  64'(m_ready()));
        cmp({tag, " halted"},    64'(halted),    64'(m_halted));
        cmp({tag, " busy_mask"}, 64'(busy_mask), m_busy());
        cmp({tag, " rd_data_a"}, rd_data_a,      m_read(int'(rd_addr_a)));
        cmp({tag, " rd_data_b"}, rd_data_b,      m_read(int'(rd_addr_b)));
        for (int r = 0; r < NR; r++) begin
            cmp($sformatf("%s reg%0d", tag, r), dut_reg(r), m_regs[r]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) check_all("mon");
    end

    task automatic put(input bit v, input bit e0, input logic [3:0] d0, input logic [63:0] v0,
                       input bit e1, input logic [3:0] d1, input logic [63:0] v1,
                       input bit h, input bit ce);
        wb_valid  = v;
        wb_en0    = e0;
        wb_dst0   = d0;
        wb_val0   = v0;
        wb_en1    = e1;
        wb_dst1   = d1;
        wb_val1   = v1;
        wb_halt   = h;
        commit_en = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ce);
        put(1'b0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, ce);
    endtask

    // Drops reset three time units after a rising edge, checks, releases off-edge.
    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        cmp("rst wb_ready", 64'(wb_ready), 64'd1);
        cmp("rst halted", 64'(halted), 64'd0);
        cmp("rst busy_mask", 64'(busy_mask), 64'd0);
        cmp("rst rd_data_a", rd_data_a, 64'd0);
        cmp("rst rd_data_b", rd_data_b, 64'd0);
        for (int r = 0; r < NR; r++) cmp($sformatf("rst reg%0d", r), dut_reg(r), 64'd0);
        check_all("rst");
        wb_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        wb_valid  = 1'b0;
        wb_en0    = 1'b0;
        wb_dst0   = '0;
        wb_val0   = '0;
        wb_en1    = 1'b0;
        wb_dst1   = '0;
        wb_val1   = '0;
        wb_halt   = 1'b0;
        commit_en = 1'b0;
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd5;
        #2;
        cmp("init wb_ready", 64'(wb_ready), 64'd1);
        cmp("init busy_mask", 64'(busy_mask), 64'd0);
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // single entry: forwardable after accept, committed one edge later
        put(1, 1, 4'd3, 64'h1234, 0, 4'd0, '0, 0, 1);
        cmp("t1 fwd r3", rd_data_a, 64'h1234);
        cmp("t1 busy", 64'(busy_mask), 64'h0008);
        cmp("t1 r3 not yet", dut_reg(3), 64'd0);
        idle(1);
        cmp("t1 r3", dut_reg(3), 64'h1234);
        cmp("t1 busy clear", 64'(busy_mask), 64'd0);

        // imul-style dual write, then same-destination collision
        put(1, 1, 4'd0, 64'hAAAA, 1, 4'd2, 64'h5555, 0, 1);
        idle(1);
        cmp("t2 rax", dut_reg(0), 64'hAAAA);
        cmp("t2 rdx", dut_reg(2), 64'h5555);
        put(1, 1, 4'd7, 64'h0111, 1, 4'd7, 64'h0777, 0, 1);
        idle(1);
        cmp("t2 r7 val1 wins", dut_reg(7), 64'h0777);

        // commit held off: queue fills, youngest forwards
        put(1, 1, 4'd5, 64'h1, 0, 4'd0, '0, 0, 0);
        put(1, 1, 4'd5, 64'h2, 0, 4'd0, '0, 0, 0);
        cmp("t3 ready full", 64'(wb_ready), 64'd0);
        cmp("t3 fwd r5", rd_data_b, 64'h2);
        cmp("t3 r5 stale", dut_reg(5), 64'd0);
        idle(1);
        cmp("t3 r5 first", dut_reg(5), 64'h1);
        idle(1);
        cmp("t3 r5 second", dut_reg(5), 64'h2);

        // halt commits, flushes the entry queued behind it
        rd_addr_a = 4'd1;
        put(1, 1, 4'd1, 64'h9, 0, 4'd0, '0, 1, 0);
        put(1, 1, 4'd1, 64'hF, 0, 4'd0, '0, 0, 0);
        idle(1);
        cmp("t4 halted", 64'(halted), 64'd1);
        cmp("t4 r1", dut_reg(1), 64'h9);
        cmp("t4 ready", 64'(wb_ready), 64'd0);
        cmp("t4 busy empty", 64'(busy_mask), 64'd0);
        put(1, 1, 4'd1, 64'hEE, 0, 4'd0, '0, 0, 1);
        idle(1);
        cmp("t4 r1 after", dut_reg(1), 64'h9);
        cmp("t4 fwd r1", rd_data_a, 64'h9);
        mid_reset();

        // back-to-back accepts with continuous commit
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 4'(8 + i % 4);
            put(1, 1, 4'(8 + i % 4), 64'(100 + i), 1, 4'(12 + i % 2), 64'(200 + i), 0, 1);
        end
        idle(1);
        idle(1);
        cmp("t5 r11", dut_reg(11), 64'd107);
        cmp("t5 r13", dut_reg(13), 64'd207);

        // reset between edges with two pending entries
        put(1, 1, 4'd4, 64'h44, 0, 4'd0, '0, 0, 0);
        put(1, 1, 4'd6, 64'h66, 1, 4'd4, 64'h45, 0, 0);
        mid_reset();

        // randomised blocks, each ended with an off-edge reset
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 60; c++) begin
                logic [3:0] d0, d1;
                d0 = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                d1 = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                rd_addr_a = 4'($urandom_range(0, 3));
                rd_addr_b = 4'($urandom_range(0, 15));
                put(($urandom % 10) < 7, $urandom % 2 == 1, d0, {$urandom, $urandom},
                    $urandom % 2 == 1, d1, {$urandom, $urandom},
                    ($urandom % 30) == 0, ($urandom % 10) < 7);
            end
            mid_reset();
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback and architectural register-file stage that sits after the ALU. The ALU emits up to two register writes per instruction (two writes for imul: rax and rdx) plus a retq flag; this block queues those results and commits them into a 16 x 64-bit register file. It serves combinational operand reads with forwarding from pending writes, and latches a halt once retq commits. It replaces the purely combinational reg_file_in/reg_file_out hand-off with a clocked, back-pressured interface.

## Interface
- NREGS, 16, number of architectural registers (index width $clog2(NREGS))
- WIDTH, 64, register width in bits
- QDEPTH, 2, writeback queue entries (power of two, >= 2)

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  ALU result offered
- wb_ready  out  1  block can accept an entry this cycle
- wb_en0 / wb_dst0 / wb_val0  in  1 / 4 / 64  first write: enable, destination, value
- wb_en1 / wb_dst1 / wb_val1  in  1 / 4 / 64  second write (imul high half)
- wb_halt  in  1  entry is a retq
- commit_en  in  1  head entry may retire this cycle
- rd_addr_a, rd_addr_b  in  4 each  operand read addresses
- rd_data_a, rd_data_b  out  64 each  forwarded read data
- busy_mask  out  16  bit r set while any queued entry writes register r
- halted  out  1  retq has committed
- reg_file  out  16*64  committed file, packed logic[0:16*64-1], register r at bits [r*64 +: 64]

## Operation
- Enqueue on the clk edge where wb_valid && wb_ready. The entry stores en0, dst0, val0, en1, dst1, val1, and halt.
- wb_ready = (count < QDEPTH) && !halted. There is no same-cycle pass-through: a full queue refuses entries even while the head retires.
- Retire: when count > 0 && commit_en, pop the head and write val0 to dst0 if en0, and val1 to dst1 if en1.
- If dst0 == dst1 with both writes enabled, the val1 write wins.
- If the head has halt=1, set halted in the same edge. Its register writes still commit.
- After halted=1, no new entries are accepted. Entries already queued behind the halt are discarded (count cleared) on the halt-commit edge.
- halted clears only on reset.
- Read forwarding, combinational, per port: return the value from the youngest queued entry that writes the address (port 1 beats port 0 within an entry). If no queued entry writes it, return the committed storage value.
- Forwarding does not include the wb_* inputs of the current cycle.
- busy_mask is the OR of the one-hot dst0 (if en0) and dst1 (if en1) over all occupied entries.
- Entries with both enables low are legal. They retire with no effect and still honour halt.

## Timing
- Reset (asynchronous assert, synchronous-safe release) clears:
  - all registers to 0, queue to empty, halted to 0
  - busy_mask to 0, rd_data_* to 0, reg_file to 0
- wb_ready reads 1 while reset_n is low.
- Latency: an entry accepted at edge N is forwardable from just after edge N. With commit_en=1 it commits at edge N+1 and is visible on reg_file after N+1.
- Throughput: one entry per cycle while commit_en is held at 1.
- Empty queue with commit_en=1: no effect.
- Enqueue and retire on the same edge: count unchanged, pointers wrap modulo QDEPTH.
- Reset asserted mid-operation: queued entries are lost, and no partial commit happens.

## Structure
- Package wb_pkg:
  - wb_entry_t packed struct (en0, dst0, val0, en1, dst1, val1, halt)
  - constants NREGS, REG_RAX=0, REG_RDX=2
  - get_64-style slice helper for the packed file
- Sub-module wb_fifo: a parameterised circular buffer of wb_entry_t. It exposes all entries plus valid bits so the parent can forward and build busy_mask.
- reg_writeback holds the storage, halt latch and forwarding muxes.

## Test plan
- Reset, then one entry (en0, dst0=3, val0=0x1234) with commit_en=1:
  - next cycle: rd_data_a(addr 3)=0x1234, busy_mask=0x0008
  - following cycle: reg_file r3=0x1234, busy_mask=0
- imul-style entry (dst0=0, val0=0xAAAA; dst1=2, val1=0x5555):
  - after commit: r0=0xAAAA, r2=0x5555
  - same-entry dst0=dst1=7 leaves r7=val1
- commit_en=0 with two entries to r5 (0x1, then 0x2):
  - wb_ready=0 and rd_data(5)=0x2 while r5 remains 0
  - raise commit_en: r5 becomes 0x1, then 0x2
- Halt entry (halt=1, writes r1=0x9) followed by a second queued entry (r1=0xF):
  - halted=1, r1=0x9, wb_ready stays 0, queue empty
- Back-to-back accepts with commit_en=1 for 8 cycles: every accepted value commits in order, and pointer wrap holds at QDEPTH=2.
- Assert reset_n low asynchronously between edges with 2 pending entries: all outputs read 0 immediately, and wb_ready reads 1.
